piece_motion_ctrl: RTL and testbench

//  Owns the falling piece position for Tetris. Each frame it proposes a candidate move
//  (keyboard left/right, then gravity/soft-drop down) to the combinational legal_move

---
 rtl/piece_motion_if.sv | 26 ++
 rtl/piece_motion_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_piece_motion_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/piece_motion_if.sv
// Signal bundle between the falling-piece controller and its neighbours:
// vsync strobe and keyboard in, legal_move verdict in, candidate/committed position out.
interface piece_motion_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       spawn;
    logic       legalX;
    logic       legalY;
    logic [9:0] PropX;
    logic [9:0] PropY;
    logic [9:0] PieceX;
    logic [9:0] PieceY;
    logic       busy;
    logic       locked;
    logic       game_over;

    modport master (
        output frame_clk, keycode, spawn, legalX, legalY,
        input  PropX, PropY, PieceX, PieceY, busy, locked, game_over
    );

    modport slave (
        input  frame_clk, keycode, spawn, legalX, legalY,
        output PropX, PropY, PieceX, PieceY, busy, locked, game_over
    );
endinterface

// File: rtl/piece_motion_ctrl.sv
// Falling-piece position owner: proposes horizontal then vertical moves each frame,
// commits what legal_move accepts, and locks the piece when it can no longer fall.
module piece_motion_ctrl #(
    parameter logic [9:0] X_START       = 10'd320,
    parameter logic [9:0] Y_START       = 10'd40,
    parameter logic [9:0] STEP          = 10'd16,
    parameter logic [5:0] DROP_FRAMES   = 6'd30,
    parameter logic [5:0] SOFT_FRAMES   = 6'd3,
    parameter logic [5:0] REPEAT_FRAMES = 6'd8
) (
    input  logic           Clk,
    input  logic           Reset_n,
    piece_motion_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FALL   = 3'd1,
        SET_H  = 3'd2,
        EVAL_H = 3'd3,
        SET_V  = 3'd4,
        EVAL_V = 3'd5,
        LOCK   = 3'd6
    } state_t;

    state_t     state_r, state_s;
    logic       frame_d_r;
    logic [7:0] key_d_r;
    logic [9:0] piece_x_r, piece_x_s, piece_y_r, piece_y_s;
    logic [9:0] prop_x_r, prop_x_s, prop_y_r, prop_y_s;
    logic [5:0] grav_cnt_r, grav_cnt_s, rep_cnt_r, rep_cnt_s;
    logic       grav_due_r, grav_due_s, h_pend_r, h_pend_s, dir_r, dir_s;
    logic       tick_pend_r, tick_pend_s;
    logic       busy_r, busy_s, locked_r, locked_s, game_over_r, game_over_s;

    logic       tick_s, tick_use_s, key_h_s, press_s, fire_s, due_s;
    logic [5:0] period_s;

    assign tick_s     = bus.frame_clk & ~frame_d_r;
    assign tick_use_s = (state_r == FALL) & (tick_s | tick_pend_r);
    assign key_h_s    = (bus.keycode == 8'h04) | (bus.keycode == 8'h07);
    assign press_s    = key_h_s & (bus.keycode != key_d_r) & (state_r != IDLE);
    // Auto-repeat counts the tick that consumed the press, so repeats land REPEAT_FRAMES apart.
    assign fire_s     = key_h_s & tick_use_s & (rep_cnt_r >= REPEAT_FRAMES);
    assign period_s   = (bus.keycode == 8'h16) ? SOFT_FRAMES : DROP_FRAMES;
    assign due_s      = grav_cnt_r >= (period_s - 6'd1);

    // Next-state and datapath decode.
    always_comb begin
        state_s     = state_r;
        piece_x_s   = piece_x_r;
        piece_y_s   = piece_y_r;
        prop_x_s    = prop_x_r;
        prop_y_s    = prop_y_r;
        grav_cnt_s  = grav_cnt_r;
        grav_due_s  = grav_due_r;
        rep_cnt_s   = rep_cnt_r;
        h_pend_s    = h_pend_r;
        dir_s       = dir_r;
        tick_pend_s = tick_pend_r;
        game_over_s = game_over_r;
        locked_s    = 1'b0;

        if (tick_use_s) begin
            grav_due_s = due_s;
            grav_cnt_s = due_s ? 6'd0 : grav_cnt_r + 6'd1;
        end else begin
            grav_due_s = grav_due_r;
        end

        if (state_r == IDLE) begin
            tick_pend_s = 1'b0;
        end else if (tick_use_s) begin
            tick_pend_s = 1'b0;
        end else if (tick_s) begin
            tick_pend_s = 1'b1;
        end else begin
            tick_pend_s = tick_pend_r;
        end

        if (press_s) begin
            rep_cnt_s = 6'd0;
        end else if (fire_s) begin
            rep_cnt_s = 6'd1;
        end else if (tick_use_s && key_h_s && (rep_cnt_r != 6'd63)) begin
            rep_cnt_s = rep_cnt_r + 6'd1;
        end else begin
            rep_cnt_s = rep_cnt_r;
        end

        if (press_s || fire_s) begin
            dir_s = (bus.keycode == 8'h07);
        end else begin
            dir_s = dir_r;
        end

        if (state_r == IDLE) begin
            h_pend_s = 1'b0;
        end else if (press_s) begin
            h_pend_s = 1'b1;
        end else if (state_r == EVAL_H) begin
            h_pend_s = 1'b0;
        end else begin
            h_pend_s = h_pend_r;
        end

        case (state_r)
            IDLE: begin
                prop_x_s = piece_x_r;
                prop_y_s = piece_y_r;
                if (bus.spawn && !game_over_r) begin
                    piece_x_s  = X_START;
                    piece_y_s  = Y_START;
                    prop_x_s   = X_START;
                    prop_y_s   = Y_START;
                    grav_cnt_s = 6'd0;
                    grav_due_s = 1'b0;
                    rep_cnt_s  = 6'd0;
                    state_s    = FALL;
                end else begin
                    state_s = IDLE;
                end
            end
            FALL: begin
                if (tick_use_s) begin
                    if (h_pend_r || fire_s) begin
                        state_s = SET_H;
                    end else if (due_s) begin
                        state_s = SET_V;
                    end else begin
                        state_s = FALL;
                    end
                end else begin
                    state_s = FALL;
                end
            end
            SET_H: begin
                prop_x_s = dir_r ? (piece_x_r + STEP) : (piece_x_r - STEP);
                prop_y_s = piece_y_r;
                state_s  = EVAL_H;
            end
            EVAL_H: begin
                if (bus.legalX && bus.legalY) begin
                    piece_x_s = prop_x_r;
                end else begin
                    piece_x_s = piece_x_r;
                end
                state_s = grav_due_r ? SET_V : FALL;
            end
            SET_V: begin
                prop_x_s = piece_x_r;
                prop_y_s = piece_y_r + STEP;
                state_s  = EVAL_V;
            end
            EVAL_V: begin
                if (bus.legalY) begin
                    piece_y_s = prop_y_r;
                    state_s   = FALL;
                end else begin
                    locked_s  = 1'b1;
                    state_s   = LOCK;
                end
            end
            LOCK: begin
                if (piece_y_r == Y_START) begin
                    game_over_s = 1'b1;
                end else begin
                    game_over_s = game_over_r;
                end
                prop_x_s = piece_x_r;
                prop_y_s = piece_y_r;
                state_s  = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_d_r   <= 1'b0;
            key_d_r     <= 8'h00;
            piece_x_r   <= X_START;
            piece_y_r   <= Y_START;
            prop_x_r    <= X_START;
            prop_y_r    <= Y_START;
            grav_cnt_r  <= 6'd0;
            grav_due_r  <= 1'b0;
            rep_cnt_r   <= 6'd0;
            h_pend_r    <= 1'b0;
            dir_r       <= 1'b0;
            tick_pend_r <= 1'b0;
            busy_r      <= 1'b0;
            locked_r    <= 1'b0;
            game_over_r <= 1'b0;
        end else begin
            frame_d_r   <= bus.frame_clk;
            key_d_r     <= bus.keycode;
            piece_x_r   <= piece_x_s;
            piece_y_r   <= piece_y_s;
            prop_x_r    <= prop_x_s;
            prop_y_r    <= prop_y_s;
            grav_cnt_r  <= grav_cnt_s;
            grav_due_r  <= grav_due_s;
            rep_cnt_r   <= rep_cnt_s;
            h_pend_r    <= h_pend_s;
            dir_r       <= dir_s;
            tick_pend_r <= tick_pend_s;
            busy_r      <= busy_s;
            locked_r    <= locked_s;
            game_over_r <= game_over_s;
        end
    end

    assign bus.PropX     = prop_x_r;
    assign bus.PropY     = prop_y_r;
    assign bus.PieceX    = piece_x_r;
    assign bus.PieceY    = piece_y_r;
    assign bus.busy      = busy_r;
    assign bus.locked    = locked_r;
    assign bus.game_over = game_over_r;
endmodule

// File: tb/tb_piece_motion_ctrl.sv
// Bench for piece_motion_ctrl: a per-frame game model predicts the committed
// position and status, checked every cycle, plus hand-computed checkpoints.
module tb_piece_motion_ctrl;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;

    piece_motion_if bus();

    piece_motion_ctrl dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int lock_cycles = 0;

    int         m_x, m_y, m_gticks, m_since;
    bit         m_busy, m_locked, m_go, m_hpend, m_dir;
    bit         chk_en = 1'b0;
    logic [7:0] m_key = 8'h00;
    logic [7:0] m_prevkey = 8'h00;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = 320; m_y = 40; m_gticks = 0; m_since = 0;
        m_busy = 1'b0; m_locked = 1'b0; m_go = 1'b0; m_hpend = 1'b0; m_dir = 1'b0;
        m_prevkey = bus.keycode;
    endtask

    // Per-cycle comparison of committed outputs against the frame model.
    always @(negedge Clk) begin
        if (chk_en) begin
            check_eq("cyc_piece_x", 32'(bus.PieceX), m_x);
            check_eq("cyc_piece_y", 32'(bus.PieceY), m_y);
            check_eq("cyc_busy", 32'(bus.busy), 32'(m_busy));
            check_eq("cyc_locked", 32'(bus.locked), 32'(m_locked));
            check_eq("cyc_game_over", 32'(bus.game_over), 32'(m_go));
        end
        if (bus.locked === 1'b1) lock_cycles++;
    end

    task automatic do_reset();
        @(posedge Clk); #1 Reset_n = 1'b0;
        @(posedge Clk); #1 model_reset(); chk_en = 1'b1;
        @(posedge Clk); #1 Reset_n = 1'b1;
    endtask

    task automatic do_spawn();
        @(posedge Clk); #1 bus.spawn = 1'b1;
        @(posedge Clk); #1 bus.spawn = 1'b0;
        if (!m_busy && !m_go) begin
            m_busy = 1'b1; m_x = 320; m_y = 40;
            m_gticks = 0; m_since = 0; m_hpend = 1'b0;
        end
        @(posedge Clk); #1;
    endtask

    task automatic set_key(input logic [7:0] k);
        @(posedge Clk); #1 bus.keycode = k;
        if (m_busy && (k == 8'h04 || k == 8'h07) && k != m_prevkey) begin
            m_hpend = 1'b1; m_dir = (k == 8'h07); m_since = 0;
        end
        m_prevkey = k;
        m_key = k;
        @(posedge Clk); #1;
    endtask

    // One frame tick: the model decides this frame's moves, then follows the DUT edge by edge.
    task automatic do_tick(input bit rst_evalv, output bit did_rst);
        bit held, hmove, vmove;
        int period, new_x;
        did_rst = 1'b0;
        held    = (m_key == 8'h04) || (m_key == 8'h07);
        period  = (m_key == 8'h16) ? 3 : 30;
        m_gticks++;
        vmove = (m_gticks >= period);
        if (vmove) m_gticks = 0;
        if (held) m_since++;
        hmove = m_hpend || (held && m_since >= 8);
        if (hmove) begin
            if (!m_hpend) m_dir = (m_key == 8'h07);
            m_hpend = 1'b0;
            m_since = 0;
        end
        @(posedge Clk); #1 bus.frame_clk = 1'b1;
        @(posedge Clk); #1 bus.frame_clk = 1'b0;
        if (hmove) begin
            new_x = m_dir ? m_x + 16 : m_x - 16;
            @(posedge Clk); #1;
            check_eq("prop_x_h", 32'(bus.PropX), new_x);
            check_eq("prop_y_h", 32'(bus.PropY), m_y);
            @(posedge Clk); #1;
            if (bus.legalX && bus.legalY) m_x = new_x;
        end
        if (vmove) begin
            @(posedge Clk); #1;
            check_eq("prop_x_v", 32'(bus.PropX), m_x);
            check_eq("prop_y_v", 32'(bus.PropY), m_y + 16);
            if (rst_evalv) Reset_n = 1'b0;
            @(posedge Clk); #1;
            if (rst_evalv) begin
                model_reset();
                Reset_n = 1'b1;
                did_rst = 1'b1;
            end else if (bus.legalY) begin
                m_y = m_y + 16;
            end else begin
                m_locked = 1'b1;
                @(posedge Clk); #1;
                m_locked = 1'b0;
                m_busy = 1'b0;
                if (m_y == 40) m_go = 1'b1;
            end
        end
        repeat (3) @(posedge Clk);
        #1;
    endtask

    initial begin
        bit d;
        int guard;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.spawn     = 1'b0;
        bus.legalX    = 1'b1;
        bus.legalY    = 1'b1;
        model_reset();

        do_reset();
        @(posedge Clk); #1;
        check_eq("rst_piece_x", 32'(bus.PieceX), 32'd320);
        check_eq("rst_piece_y", 32'(bus.PieceY), 32'd40);
        check_eq("rst_prop_x", 32'(bus.PropX), 32'd320);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_locked", 32'(bus.locked), 32'd0);

        do_spawn();
        check_eq("spawn_busy", 32'(bus.busy), 32'd1);

        for (int i = 0; i < 30; i++) do_tick(1'b0, d);
        check_eq("grav30_y", 32'(bus.PieceY), 32'd56);
        for (int i = 0; i < 30; i++) do_tick(1'b0, d);
        check_eq("grav60_y", 32'(bus.PieceY), 32'd72);
        check_eq("grav60_x", 32'(bus.PieceX), 32'd320);

        set_key(8'h04);
        do_tick(1'b0, d);
        check_eq("left_press_x", 32'(bus.PieceX), 32'd304);
        for (int i = 0; i < 7; i++) do_tick(1'b0, d);
        check_eq("left_hold7_x", 32'(bus.PieceX), 32'd304);
        do_tick(1'b0, d);
        check_eq("left_repeat_x", 32'(bus.PieceX), 32'd288);

        set_key(8'h00);
        set_key(8'h07);
        bus.legalX = 1'b0;
        do_tick(1'b0, d);
        check_eq("right_blocked_x", 32'(bus.PieceX), 32'd288);
        check_eq("right_blocked_busy", 32'(bus.busy), 32'd1);
        check_eq("right_blocked_nolock", 32'(lock_cycles), 32'd0);
        bus.legalX = 1'b1;

        set_key(8'h16);
        guard = 0;
        while (m_y < 200 && guard < 200) begin
            do_tick(1'b0, d);
            guard++;
        end
        check_eq("soft_reach_y", 32'(bus.PieceY), 32'd200);
        bus.legalY = 1'b0;
        guard = 0;
        while (m_busy && guard < 20) begin
            do_tick(1'b0, d);
            guard++;
        end
        check_eq("lock200_pulses", 32'(lock_cycles), 32'd1);
        check_eq("lock200_busy", 32'(bus.busy), 32'd0);
        check_eq("lock200_y", 32'(bus.PieceY), 32'd200);
        check_eq("lock200_go", 32'(bus.game_over), 32'd0);

        do_spawn();
        guard = 0;
        while (m_busy && guard < 20) begin
            do_tick(1'b0, d);
            guard++;
        end
        check_eq("lock40_go", 32'(bus.game_over), 32'd1);
        check_eq("lock40_pulses", 32'(lock_cycles), 32'd2);
        bus.legalY = 1'b1;
        do_spawn();
        check_eq("go_spawn_ignored", 32'(bus.busy), 32'd0);
        check_eq("go_sticky", 32'(bus.game_over), 32'd1);

        do_reset();
        check_eq("rst_clears_go", 32'(bus.game_over), 32'd0);
        do_spawn();
        guard = 0;
        d = 1'b0;
        while (!d && guard < 20) begin
            do_tick(1'b1, d);
            guard++;
        end
        check_eq("rst_evalv_happened", 32'(d), 32'd1);
        check_eq("rst_evalv_y", 32'(bus.PieceY), 32'd40);
        check_eq("rst_evalv_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_evalv_nolock", 32'(lock_cycles), 32'd2);
        do_spawn();
        check_eq("post_rst_spawn", 32'(bus.busy), 32'd1);

        repeat (2) @(posedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
